ldtu_decoder: RTL
=================

// Module: ldtu_decoder
// PURPOSE
//  Back-end decoder for the LiTe-DTU 32-bit encoded word stream.
//  - Takes words qualified by Load and expands each into its 13-bit samples, one per cycle.
//  - Samples leave on a valid/ready stream with a baseline/signal tag.
//  - Sits on the receive side, in the test bench or the back-end model, after word re-alignment.
// PARAMETERS
//  Nbits_32  32  encoded word width
//  Nbits_12  12  MSB index of a signal sample (samples are Nbits_12+1 = 13 bits)
//  Nbits_6    6  baseline sample width
//  ERRW      16  width of the error counter (DEC_ERR_CNT_EN only)
// PORTS
//  CLK        in   1   clock
//  reset      in   1   synchronous reset, active-high
//  DATA_32    in   32  encoded word
//  Load       in   1   DATA_32 valid this cycle
//  ready_in   out  1   decoder can accept a word this cycle
//  DATA_out   out  13  decoded sample; baseline samples are zero-extended
//  bas_out    out  1   1 = DATA_out is a baseline (6-bit) sample
//  valid_out  out  1   DATA_out/bas_out valid
//  ready_out  in   1   downstream accepts a sample
//  code_err   out  1   one-cycle pulse: malformed word dropped
//  ovf_err    out  1   sticky: Load seen while ready_in=0
//  err_count  out  ERRW  saturating error count (DEC_ERR_CNT_EN only)
// BEHAVIOUR
//  Reset (sync, reset=1 at posedge)
//   - All outputs go to 0, except ready_in=1.
//   - Holding register and sample counter cnt are cleared; the word in flight is lost.
//  Header decode on an accepted word (Load & ready_in):
//   - [31:30]=01: 5 baseline samples; s1=[5:0], s2=[11:6] ... s5=[29:24].
//   - [31:30]=10: N=[29:24] baseline samples at [6N-1:0], s1 at LSB. N must be 1..4.
//   - [31:26]=001010: 2 signal samples; s1=[12:0], s2=[25:13].
//   - [31:26]=001011: 1 signal sample s1=[12:0]; [25:13] must equal 13'b0101010101010.
//   - [31:30]=11: idle/initial word (e.g. 32'hF0000000). Dropped silently, no error.
//   - Anything else is a code error: header 00 other than 001010/001011, N=0 or N>4, or sync mismatch.
//     The word is dropped and code_err pulses in the cycle after acceptance.
//  States: EMPTY (cnt=0) and EMIT (cnt=1..5).
//   - Accepting a valid word loads the samples and sets cnt=N, giving EMIT.
//   - The first sample is valid on the cycle after acceptance (latency 1).
//   - Emission order is s1 first, then ascending.
//   - cnt decrements on each valid_out & ready_out. When cnt reaches 0 the block returns to EMPTY.
//  Handshake rules
//   - While valid_out=1 and ready_out=0, DATA_out and bas_out hold stable.
//   - ready_in = (cnt==0) | (cnt==1 & ready_out), combinational.
//   - Back-to-back words produce no bubble: the last sample of one word is followed by the
//     first sample of the next word in the next cycle.
//  Overflow
//   - Load with ready_in=0: the word is discarded and the current word is undisturbed.
//   - ovf_err is set and stays set until reset.
//  Arithmetic
//   - cnt is 3 bits.
//   - Baseline samples are output as {7'b0, s[5:0]}.
// CONFIGURATION
//  DEC_ERR_CNT_EN defined:
//   - err_count increments by 1 on each code_err pulse and on each overflow event.
//   - If both occur in the same cycle it increments by 2.
//   - It saturates at all-ones and is cleared by reset.
//  DEC_ERR_CNT_EN undefined: the err_count port and its logic are absent.
// TESTING
//  1. Word 32'h45103081 with Load=1, ready_out=1
//     -> DATA_out 1,2,3,4,5 on 5 consecutive cycles, bas_out=1.
//  2. Word 32'h2B578123 -> DATA_out 13'h0123 then 13'h1ABC, bas_out=0.
//     Word 32'h2D555FFF -> a single sample 13'h1FFF.
//  3. Word 32'h82000FC1 -> samples 13'h001, 13'h03F.
//     Word 32'h80000000 (N=0) -> code_err pulse, no valid_out.
//  4. Word 32'h00000000 -> code_err pulse, no output.
//     Word 32'hF0000000 -> no output, no error.
//  5. Hold ready_out=0 while valid_out=1 and drive a second Load
//     -> DATA_out stable, second word dropped, ovf_err=1 until reset.
//  6. Assert reset mid-word (cnt=3)
//     -> next cycle valid_out=0, ready_in=1, ovf_err=0; err_count=0 under DEC_ERR_CNT_EN.

Source files
------------

// File: rtl/ldtu_decoder_if.sv
// Word-in / sample-out stream bundle for the LiTe-DTU decoder.
// The decoder uses the slave view; the producer/consumer side uses master.
interface ldtu_decoder_if #(
    parameter int Nbits_32 = 32,
    parameter int Nbits_12 = 12
);
    logic [Nbits_32-1:0] DATA_32;
    logic                Load;
    logic                ready_in;
    logic [Nbits_12:0]   DATA_out;
    logic                bas_out;
    logic                valid_out;
    logic                ready_out;

    modport slave (
        input  DATA_32, Load, ready_out,
        output ready_in, DATA_out, bas_out, valid_out
    );

    modport master (
        output DATA_32, Load, ready_out,
        input  ready_in, DATA_out, bas_out, valid_out
    );
endinterface

// File: rtl/ldtu_decoder.sv
// LiTe-DTU back-end decoder: expands each accepted 32-bit word into 13-bit samples, one per cycle.
// Optional saturating error counter enabled by defining DEC_ERR_CNT_EN.
module ldtu_decoder #(
    parameter int Nbits_32 = 32,
    parameter int Nbits_12 = 12,
    parameter int Nbits_6  = 6
`ifdef DEC_ERR_CNT_EN
    ,
    parameter int ERRW     = 16
`endif
) (
    input  logic            CLK,
    input  logic            reset,
    ldtu_decoder_if.slave   dec,
    output logic            code_err,
    output logic            ovf_err
`ifdef DEC_ERR_CNT_EN
    ,
    output logic [ERRW-1:0] err_count
`endif
);

    localparam int SW = Nbits_12 + 1;
    localparam logic [SW-1:0] SYNC_PATTERN = 13'b0101010101010;

    typedef enum logic {EMPTY, EMIT} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q;
    logic [Nbits_32-1:0] hold_q;
    logic                bas_q;

    logic                valid, ready, fire, accept, ovf_event;
    logic                dec_load, dec_err, dec_bas;
    logic [2:0]          dec_n;
    logic [Nbits_32-1:0] word;

    assign word = dec.DATA_32;

    // Header decode of the word currently on the input bus.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_load = 1'b0;
        dec_err  = 1'b0;
        dec_bas  = 1'b0;
        dec_n    = 3'd0;
        case (word[31:30])
            2'b01: begin
                dec_load = 1'b1;
                dec_bas  = 1'b1;
                dec_n    = 3'd5;
            end
            2'b10: begin
                if (word[29:24] >= 6'd1 && word[29:24] <= 6'd4) begin
                    dec_load = 1'b1;
                    dec_bas  = 1'b1;
                    dec_n    = word[26:24];
                end else begin
                    dec_err = 1'b1;
                end
            end
            2'b11: ;  // idle/initial word: dropped silently
            default: begin
                if (word[29:26] == 4'b1010) begin
                    dec_load = 1'b1;
                    dec_n    = 3'd2;
                end else if (word[29:26] == 4'b1011 && word[25:13] == SYNC_PATTERN) begin
                    dec_load = 1'b1;
                    dec_n    = 3'd1;
                end else begin
                    dec_err = 1'b1;
                end
            end
        endcase
    end

    // Handshake and next state; a word is accepted in the same cycle the last sample leaves.
    always_comb begin
        state_d   = state_q;
        valid     = (state_q == EMIT);
        ready     = (cnt_q == 3'd0) | ((cnt_q == 3'd1) & dec.ready_out);
        fire      = valid & dec.ready_out;
        accept    = dec.Load & ready;
        ovf_event = dec.Load & ~ready;
        case (state_q)
            EMPTY: if (accept && dec_load) state_d = EMIT;
            EMIT: begin
                if (accept && dec_load)            state_d = EMIT;
                else if (fire && cnt_q == 3'd1)    state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the holding register is cleared on reset too, so DATA_out never exposes a stale word.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= EMPTY;
            cnt_q    <= 3'd0;
            hold_q   <= '0;
            bas_q    <= 1'b0;
            code_err <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_err <= accept & dec_err;
            ovf_err  <= ovf_err | ovf_event;
            if (accept && dec_load) begin
                hold_q <= word;
                bas_q  <= dec_bas;
                cnt_q  <= dec_n;
            end else if (fire) begin
                hold_q <= bas_q ? (hold_q >> Nbits_6) : (hold_q >> SW);
                cnt_q  <= cnt_q - 3'd1;
            end
        end
    end

    assign dec.ready_in  = ready;
    assign dec.valid_out = valid;
    assign dec.bas_out   = valid & bas_q;
    assign dec.DATA_out  = !valid ? '0
                         : bas_q ? {{(SW-Nbits_6){1'b0}}, hold_q[Nbits_6-1:0]}
                         : hold_q[SW-1:0];

`ifdef DEC_ERR_CNT_EN
    // A registered code_err pulse and a fresh overflow can coincide, giving +2.
    logic [1:0]    err_inc;
    logic [ERRW:0] err_sum;

    assign err_inc = {1'b0, code_err} + {1'b0, ovf_event};
    assign err_sum = {1'b0, err_count} + {{(ERRW-1){1'b0}}, err_inc};

    always_ff @(posedge CLK) begin
        if (reset)            err_count <= '0;
        else if (err_sum[ERRW]) err_count <= '1;
        else                  err_count <= err_sum[ERRW-1:0];
    end
`endif

endmodule
